spi_dac_sequencer: RTL and testbench

Parametrised multi-channel serial DAC writer. Accepts one sample per channel through a valid/ready handshake, then shifts each enabled channel out MSB-first on a shared SCLK/SDATA pair. Each channel has its own active-low chip select, and SCLK is divided down from the system clock. It sits between the waveform/ramp generators and the off-chip DAC pins, replacing the fixed single-channel 14-bit writer.

---
 rtl/spi_dac_pkg.sv | 19 +
 rtl/spi_dac_shifter.sv | 66 ++++++
 rtl/spi_dac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_dac_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared state encoding and counter width helpers for the SPI DAC sequencer.
// SPI_DAC_LDAC_EN adds the LDAC state.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
`ifdef SPI_DAC_LDAC_EN
        ,
        S_LDAC
`endif
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_dac_shifter.sv
// One chip-select frame: FRAME_W bits MSB-first, SCLK low then high for
// CLK_DIV cycles each, data only moving while SCLK is low.
module spi_dac_shifter
    import spi_dac_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              sclk,
    output logic              sdata,
    output logic              active,
    output logic              last
);

    localparam int BW = cnt_w(FRAME_W);
    localparam int VW = cnt_w(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(CLK_DIV - 1);

    logic [FRAME_W-1:0] shreg;
    logic [BW-1:0]      bit_cnt;
    logic [VW-1:0]      div_cnt;
    logic               phase;
    logic               half_end;

    assign half_end = active && (div_cnt == DIV_LAST);
    assign last     = half_end && phase && (bit_cnt == BIT_LAST);
    assign sclk     = active && phase;
    assign sdata    = active && shreg[FRAME_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            shreg   <= FRAME_W'(data) << (FRAME_W - DATA_W);
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                phase   <= ~phase;
                // End of the high half: advance to the next bit.
                if (phase) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last)
                        active <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_dac_sequencer.sv
// Multi-channel serial DAC writer: handshake, channel walk, chip selects.
// Optional SPI_DAC_LDAC_EN adds an ldac_n pulse before done.
module spi_dac_sequencer
    import spi_dac_pkg::*;
#(
    parameter int DATA_W   = 14,
    parameter int FRAME_W  = 16,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic [CHANNELS-1:0]        in_mask,
    output logic                       sclk,
    output logic                       sdata,
    output logic [CHANNELS-1:0]        cs_n,
    output logic                       done
`ifdef SPI_DAC_LDAC_EN
    ,
    output logic                       ldac_n
`endif
);

    if (FRAME_W < DATA_W) begin : g_bad_frame
        $error("FRAME_W must be at least DATA_W");
    end

    localparam int CW = cnt_w(CHANNELS);
    localparam int WW = cnt_w(2 * CLK_DIV);
    localparam logic [WW-1:0] GAP_LAST = WW'(CLK_DIV - 1);
`ifdef SPI_DAC_LDAC_EN
    localparam logic [WW-1:0] LDAC_LAST = WW'(2 * CLK_DIV - 1);
`endif

    state_t                      state, state_n;
    logic [CW-1:0]               ch, ch_n, first, nxt;
    logic                        has_nxt;
    logic [WW-1:0]               wait_cnt;
    logic [CHANNELS*DATA_W-1:0]  data_q;
    logic [CHANNELS-1:0]         mask_q;
    logic                        done_q, done_n;
    logic                        latch, start, accept;
    logic [DATA_W-1:0]           start_word;
    logic                        frame_active, frame_last;

    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign done     = done_q;
`ifdef SPI_DAC_LDAC_EN
    assign ldac_n   = (state != S_LDAC);
`endif

    always_comb begin
        cs_n = '1;
        if (frame_active)
            cs_n[ch] = 1'b0;
    end

    // Lowest enabled channel of the offer, and next enabled one above ch.
    always_comb begin
        first   = '0;
        nxt     = '0;
        has_nxt = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_mask[i])
                first = CW'(i);
            if (mask_q[i] && (i > int'(ch))) begin
                nxt     = CW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        ch_n       = ch;
        start      = 1'b0;
        latch      = 1'b0;
        done_n     = 1'b0;
        start_word = data_q[int'(nxt)*DATA_W +: DATA_W];
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    latch = 1'b1;
                    if (|in_mask) begin
                        state_n    = S_SHIFT;
                        ch_n       = first;
                        start      = 1'b1;
                        start_word = in_data[int'(first)*DATA_W +: DATA_W];
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (frame_last)
                    state_n = S_GAP;
            end
            S_GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    if (has_nxt) begin
                        state_n = S_SHIFT;
                        ch_n    = nxt;
                        start   = 1'b1;
                    end else begin
`ifdef SPI_DAC_LDAC_EN
                        state_n = S_LDAC;
`else
                        state_n = S_IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef SPI_DAC_LDAC_EN
            S_LDAC: begin
                if (wait_cnt == LDAC_LAST) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ch       <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
            data_q   <= '0;
            mask_q   <= '0;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            done_q   <= done_n;
            wait_cnt <= (state_n != state) ? '0 : wait_cnt + 1'b1;
            if (latch) begin
                data_q <= in_data;
                mask_q <= in_mask;
            end
        end
    end

    spi_dac_shifter #(
        .DATA_W  (DATA_W),
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (start_word),
        .sclk   (sclk),
        .sdata  (sdata),
        .active (frame_active),
        .last   (frame_last)
    );

endmodule

// File: tb/tb_spi_dac_sequencer.sv
// Bench for spi_dac_sequencer: two instances (CLK_DIV 1 and 3) checked
// cycle by cycle against an arithmetic timeline model.
module tb_spi_dac_sequencer;

    localparam int DW = 14;
    localparam int FW = 16;
`ifdef SPI_DAC_LDAC_EN
    localparam int LDAC_MUL = 2;
`else
    localparam int LDAC_MUL = 0;
`endif

    typedef struct packed {
        logic [1:0] cs_n;
        logic       sclk;
        logic       sdata;
        logic       done;
        logic       ready;
        logic       ldac_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b;
    logic [27:0] in_data;
    logic [1:0]  in_mask;
    logic        rdy_a, rdy_b, sclk_a, sclk_b, sd_a, sd_b, done_a, done_b;
    logic [1:0]  cs_a, cs_b;
    logic        ldac_a, ldac_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    spi_dac_sequencer #(.DATA_W(DW), .FRAME_W(FW), .CHANNELS(2), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_ready(rdy_a),
        .in_data(in_data), .in_mask(in_mask), .sclk(sclk_a), .sdata(sd_a),
        .cs_n(cs_a), .done(done_a)
`ifdef SPI_DAC_LDAC_EN
        , .ldac_n(ldac_a)
`endif
    );

    spi_dac_sequencer #(.DATA_W(DW), .FRAME_W(FW), .CHANNELS(2), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(rdy_b),
        .in_data(in_data), .in_mask(in_mask), .sclk(sclk_b), .sdata(sd_b),
        .cs_n(cs_b), .done(done_b)
`ifdef SPI_DAC_LDAC_EN
        , .ldac_n(ldac_b)
`endif
    );

`ifndef SPI_DAC_LDAC_EN
    assign ldac_a = 1'b1;
    assign ldac_b = 1'b1;
`endif

    function automatic int fin_of(input int d, input logic [1:0] m);
        int n;
        n = int'(m[0]) + int'(m[1]);
        if (n == 0)
            return 1;
        return 1 + n * (2 * d * FW + d) + LDAC_MUL * d;
    endfunction

    // Expected outputs t cycles after the accept cycle.
    function automatic exp_t model(input int t, input int d,
                                   input logic [1:0] m, input logic [27:0] w);
        exp_t e;
        int   en[$];
        int   len, fin, j, r, k;
        e = '{cs_n: 2'b11, sclk: 1'b0, sdata: 1'b0, done: 1'b0,
              ready: 1'b0, ldac_n: 1'b1};
        for (int c = 0; c < 2; c++)
            if (m[c])
                en.push_back(c);
        len = 2 * d * FW + d;
        fin = fin_of(d, m);
        if (t >= fin) begin
            e.ready = 1'b1;
            e.done  = (t == fin);
            return e;
        end
        j = (t - 1) / len;
        r = (t - 1) % len;
        if (j < en.size()) begin
            if (r < 2 * d * FW) begin
                k = r / (2 * d);
                e.cs_n[en[j]] = 1'b0;
                e.sclk  = (r % (2 * d)) >= d;
                e.sdata = (k < DW) ? w[en[j] * DW + DW - 1 - k] : 1'b0;
            end
        end else begin
            e.ldac_n = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp(input bit sel, input exp_t e, input string ph);
        chk({ph, ".cs_n"},  32'(sel ? cs_b   : cs_a),   32'(e.cs_n));
        chk({ph, ".sclk"},  32'(sel ? sclk_b : sclk_a), 32'(e.sclk));
        chk({ph, ".sdata"}, 32'(sel ? sd_b   : sd_a),   32'(e.sdata));
        chk({ph, ".done"},  32'(sel ? done_b : done_a), 32'(e.done));
        chk({ph, ".ready"}, 32'(sel ? rdy_b  : rdy_a),  32'(e.ready));
        chk({ph, ".ldac"},  32'(sel ? ldac_b : ldac_a), 32'(e.ldac_n));
    endtask

    localparam exp_t RST_E  = '{cs_n: 2'b11, sclk: 1'b0, sdata: 1'b0,
                                done: 1'b0, ready: 1'b0, ldac_n: 1'b1};
    localparam exp_t IDLE_E = '{cs_n: 2'b11, sclk: 1'b0, sdata: 1'b0,
                                done: 1'b0, ready: 1'b1, ldac_n: 1'b1};

    task automatic idle(input bit sel, input int n);
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cmp(sel, IDLE_E, "idle");
        end
    endtask

    // Offers (m, w) in the current cycle, then checks every following cycle
    // up to done. Mid-transfer inputs are scrambled; hold keeps valid high.
    task automatic xfer(input bit sel, input logic [1:0] m, input logic [27:0] w,
                        input bit hold, input int abort_at);
        int d, fin;
        d   = sel ? 3 : 1;
        fin = fin_of(d, m);
        in_data = w;
        in_mask = m;
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        chk("accept.ready", 32'(sel ? rdy_b : rdy_a), 32'd1);
        for (int t = 1; t <= fin; t++) begin
            @(negedge clk);
            cmp(sel, model(t, d, m, w), "xfer");
            if (!hold) begin
                valid_a = 1'b0;
                valid_b = 1'b0;
            end
            if (t < fin) begin
                in_data = 28'($urandom);
                in_mask = 2'($urandom);
            end
            if (t == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                cmp(sel, RST_E, "abort");
                rst = 1'b0;
                idle(sel, 2 * fin);
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        in_data = '0;
        in_mask = '0;
        repeat (3) @(negedge clk);
        cmp(1'b0, RST_E, "reset");
        cmp(1'b1, RST_E, "reset");
        rst = 1'b0;
        idle(1'b0, 2);
        idle(1'b1, 1);

        xfer(1'b0, 2'b11, {14'h0001, 14'h2A55}, 1'b0, 0);
        idle(1'b0, 2);
        xfer(1'b0, 2'b10, 28'($urandom), 1'b0, 0);
        idle(1'b0, 1);
        xfer(1'b0, 2'b00, 28'($urandom), 1'b0, 0);
        idle(1'b0, 1);
        xfer(1'b1, 2'b01, {14'h0000, 14'h3FFF}, 1'b0, 0);
        idle(1'b1, 2);

        xfer(1'b0, 2'b11, 28'($urandom), 1'b1, 0);
        xfer(1'b0, 2'b01, 28'($urandom), 1'b1, 0);
        xfer(1'b0, 2'b10, 28'($urandom), 1'b0, 0);
        idle(1'b0, 2);

        xfer(1'b0, 2'b11, 28'($urandom), 1'b0, 10);
        xfer(1'b1, 2'b11, 28'($urandom), 1'b0, 25);

        for (int i = 0; i < 10; i++) begin
            bit          s;
            logic [1:0]  m;
            logic [27:0] w;
            s = 1'($urandom);
            m = 2'($urandom);
            w = 28'($urandom);
            xfer(s, m, w, 1'b0, 0);
            idle(s, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
